proc_param: RTL
===============

# proc_param

Parametrised multicycle processor: the next generation of the team's 16-bit bus-based processor. Data width and register count are generalised. The ALU gains logic operations, and the block adds carry/zero flags, a conditional move, and an explicit run/done/busy handshake. It executes one instruction per `run` request on a single shared `bus`. It is intended as the core of the next processor top level and its testbench.

## Interface
- `WIDTH`, default 16: instruction and data width. Must satisfy `WIDTH >= 3 + 2*RBITS + 1`.
- `RBITS`, default 3: register-select field width. There are `2**RBITS` registers R0..R(2**RBITS-1).
- `clock`, input, 1 bit: single clock. All state changes on the rising edge.
- `reset`, input, 1 bit: synchronous, active-high reset.
- `run`, input, 1 bit: start request, sampled only in IDLE.
- `iin`, input, `WIDTH` bits: instruction word, latched into IR when a start is accepted.
- `bus`, output, `WIDTH` bits: shared datapath bus; shows the value being moved or computed.
- `done`, output, 1 bit: high during the final cycle of an instruction.
- `busy`, output, 1 bit: high in every state except IDLE.
- `flags`, output, 2 bits: {C, Z}.

## Operation
- Instruction fields, from the MSB down: opcode[2:0] | rX[RBITS] | rY[RBITS] | remaining bits.
- mvi immediate = `iin[WIDTH-4-RBITS:0]`, zero-extended. This is 10 bits at the defaults.
- Opcodes:
  - 000 mv: rX <= rY.
  - 001 mvi: rX <= imm.
  - 010 add: rX <= rX + rY.
  - 011 sub: rX <= rX - rY.
  - 100 and.
  - 101 or.
  - 110 xor.
  - 111 mvnz: rX <= rY only when Z == 0.
- States: IDLE, T1, T2, T3.
  - IDLE: `bus` = 0. When `run` = 1, IR <= `iin` and go to T1; otherwise stay.
  - T1, move ops (mv, mvi, mvnz): `bus` = source (rY or imm), `done` = 1. At the edge, rX <= `bus`, except mvnz with Z = 1, which writes nothing. Then go to IDLE.
  - T1, ALU ops: `bus` = rX, A <= `bus`, go to T2.
  - T2: `bus` = rY, G <= A op `bus`, flags updated, go to T3.
  - T3: `bus` = G, `done` = 1, rX <= G, go to IDLE.
- Arithmetic is modulo `2**WIDTH`.
  - add: C = carry out of bit WIDTH-1.
  - sub: C = borrow, i.e. 1 when A < rY unsigned.
  - and/or/xor: C = 0.
  - Z = (result == 0) for all ALU ops.
- Only ALU ops modify the flags. Move ops never change them.
- rX == rY is legal. The operand values are the pre-instruction values; e.g. sub R0,R0 gives 0 with Z = 1.
- `run` while `busy` is ignored. It is not queued.
- `iin` is sampled only on the accepting edge and may change afterwards.

## Timing
- Reset (synchronous, takes priority over everything) sets:
  - state = IDLE;
  - all registers, IR, A and G = 0;
  - `flags` = 00;
  - `done` = 0, `busy` = 0, `bus` = 0.
- Reset asserted mid-instruction aborts it: there is no register write, and `done` is not asserted.
- Latency, counted from the edge that accepts `run`:
  - move ops: `done` in the next cycle (2 cycles total including IDLE);
  - ALU ops: `done` in the third cycle (4 cycles total).
- The destination register and flags are visible from the edge ending the `done` cycle.
- `done` and `busy` are combinational decodes of the state; `done` is high for exactly one cycle.
- A new `run` is accepted no earlier than the edge after the `done` cycle. Holding `run` high therefore starts back-to-back instructions, with one IDLE cycle between them.

## Test plan
All scenarios use WIDTH = 16, RBITS = 3.
1. Reset: assert `reset` for 2 cycles, then release -> `bus` = 0, `done` = 0, `busy` = 0, `flags` = 00. Then mv R3,R5 -> `bus` = 0x0000 in T1.
2. mvi R0,#28 (`iin` = 001_000_000_0011100), then mv R2,R0 -> first: `done` 1 cycle after accept with `bus` = 0x001C; second: `bus` = 0x001C, R2 = 0x001C.
3. mvi R1,#10, then add R0,R1 -> T1 `bus` = 0x001C, T2 `bus` = 0x000A, T3 `bus` = 0x0026 with `done`; `flags` = 00.
4. mvi R4,#0, mvi R5,#1, sub R4,R5 -> 0xFFFF with C = 1, Z = 0. Then add R4,R5 -> 0x0000 with C = 1, Z = 1. Then mvnz R6,R5 -> no write: a following mv R7,R6 shows 0x0000.
5. xor R1,R1 -> Z = 1, C = 0. Then or R1,R0 (R0 = 0x0026) -> 0x0026, Z = 0. Then mvnz R6,R1 -> R6 = 0x0026.
6. Start add R0,R1. Hold `run` high throughout and pulse `reset` in T2 -> next cycle IDLE, R0 = 0, no `done`. Separately, a `run` edge while `busy` -> no extra instruction executes.

Source files
------------

// File: rtl/proc_param.sv
// Parametrised multicycle processor: executes one instruction per accepted run on a shared bus.
// Latency: move ops finish one cycle after accept, ALU ops finish three cycles after accept.
// Backpressure: run is sampled only in IDLE; a run while busy is dropped, never queued.
module proc_param #(
    parameter int WIDTH = 16,
    parameter int RBITS = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic [WIDTH-1:0] iin,
    output logic [WIDTH-1:0] bus,
    output logic             done,
    output logic             busy,
    output logic [1:0]       flags
);

    localparam int NREG = 2 ** RBITS;
    // Immediate occupies everything below the opcode and rX fields
    localparam int IMMW = WIDTH - 3 - RBITS;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_MVNZ = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_T1   = 2'd1,
        S_T2   = 2'd2,
        S_T3   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   regs_q [NREG];
    logic [WIDTH-1:0]   ir_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   g_q;
    logic [1:0]         flags_q;   // {C, Z}

    logic [2:0]         op;
    logic [RBITS-1:0]   rx;
    logic [RBITS-1:0]   ry;
    logic [WIDTH-1:0]   imm;
    logic               is_move;
    logic [WIDTH:0]     alu_ext;   // extra MSB carries add carry / sub borrow
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;

    assign op      = ir_q[WIDTH-1 -: 3];
    assign rx      = ir_q[WIDTH-4 -: RBITS];
    assign ry      = ir_q[WIDTH-4-RBITS -: RBITS];
    assign imm     = {{(WIDTH-IMMW){1'b0}}, ir_q[IMMW-1:0]};
    assign is_move = (op == OP_MV) || (op == OP_MVI) || (op == OP_MVNZ);

    assign busy  = (state_q != S_IDLE);
    assign flags = flags_q;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, bus source selection and done decode
    always_comb begin
        state_d = state_q;
        bus     = '0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_T1;
                end
            end
            S_T1: begin
                if (is_move) begin
                    bus     = (op == OP_MVI) ? imm : regs_q[ry];
                    done    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    bus     = regs_q[rx];
                    state_d = S_T2;
                end
            end
            S_T2: begin
                bus     = regs_q[ry];
                state_d = S_T3;
            end
            S_T3: begin
                bus     = g_q;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ALU: combines latched A with the second operand currently on the bus
    always_comb begin
        alu_ext = '0;
        case (op)
            OP_ADD:  alu_ext = {1'b0, a_q} + {1'b0, bus};
            OP_SUB:  alu_ext = {1'b0, a_q} - {1'b0, bus};
            OP_AND:  alu_ext = {1'b0, a_q & bus};
            OP_OR:   alu_ext = {1'b0, a_q | bus};
            OP_XOR:  alu_ext = {1'b0, a_q ^ bus};
            default: alu_ext = '0;
        endcase
        alu_res = alu_ext[WIDTH-1:0];
        alu_c   = alu_ext[WIDTH];
    end

    // Datapath registers: IR capture, A/G staging, flag update and register write-back
    always_ff @(posedge clock) begin
        if (reset) begin
            ir_q    <= '0;
            a_q     <= '0;
            g_q     <= '0;
            flags_q <= 2'b00;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (run) begin
                        ir_q <= iin;
                    end
                end
                S_T1: begin
                    if (is_move) begin
                        // mvnz suppresses the write while the last ALU result was zero
                        if (!((op == OP_MVNZ) && flags_q[0])) begin
                            regs_q[rx] <= bus;
                        end
                    end else begin
                        a_q <= bus;
                    end
                end
                S_T2: begin
                    g_q     <= alu_res;
                    flags_q <= {alu_c, (alu_res == '0)};
                end
                S_T3: begin
                    regs_q[rx] <= g_q;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
